// File: rtl/bram_word_port.sv
// 32-bit word request port onto an 8-bit BRAM port: a word access is split
// into four sequential byte-lane accesses with fixed read/write latency.
module bram_word_port #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [7:0]        ram_din,
  output logic              ram_ce,
  output logic              ram_wre,
  output logic              ram_oce,
  output logic              ram_reset,
  input  logic [7:0]        ram_dout
);

  localparam int unsigned WORD_W = ADDR_W - 2;
  localparam int unsigned LANE_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD      = 2'd1,
    RD_TAIL = 2'd2,
    WR      = 2'd3
  } state_t;

  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] word;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
  } req_t;

  state_t              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  req_t                req_q, req_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                cap_vld_q, cap_vld_d;
  logic [LANE_W-1:0]   cap_lane_q, cap_lane_d;
  logic                ce_q, ce_d;
  logic                wre_q, wre_d;
  logic [ADDR_W-1:0]   ad_q, ad_d;
  logic [7:0]          din_q, din_d;

  // Byte offset within the word is implied by the lane counter.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];

  // Next state, lane sequencing, read capture and next BRAM drive.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    req_d       = req_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    cap_vld_d   = (state_q == RD);
    cap_lane_d  = lane_q;
    ce_d        = 1'b0;
    wre_d       = 1'b0;
    ad_d        = '0;
    din_d       = '0;

    // BRAM data lags the issued lane by one cycle.
    if (cap_vld_q) begin
      rdata_d[{cap_lane_q, 3'b000} +: 8] = ram_dout;
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d     = req_we ? WR : RD;
          lane_d      = '0;
          req_d.we    = req_we;
          req_d.word  = req_addr[ADDR_W-1:2];
          req_d.wdata = req_wdata;
          req_d.wstrb = req_wstrb;
        end
      end
      RD: begin
        lane_d = lane_q + LANE_W'(1);
        if (lane_q == LANE_W'(3)) begin
          state_d = RD_TAIL;
        end
      end
      RD_TAIL: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
      end
      WR: begin
        lane_d = lane_q + LANE_W'(1);
        if (lane_q == LANE_W'(3)) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Lane address keeps the latched word bits: no carry across words.
    case (state_d)
      RD: begin
        ce_d = 1'b1;
        ad_d = {req_d.word, lane_d};
      end
      WR: begin
        ce_d  = req_d.wstrb[lane_d];
        wre_d = req_d.wstrb[lane_d];
        ad_d  = {req_d.word, lane_d};
        din_d = req_d.wdata[{lane_d, 3'b000} +: 8];
      end
      default: begin
        ce_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      req_q       <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      cap_vld_q   <= 1'b0;
      cap_lane_q  <= '0;
      ce_q        <= 1'b0;
      wre_q       <= 1'b0;
      ad_q        <= '0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      req_q       <= req_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      cap_vld_q   <= cap_vld_d;
      cap_lane_q  <= cap_lane_d;
      ce_q        <= ce_d;
      wre_q       <= wre_d;
      ad_q        <= ad_d;
      din_q       <= din_d;
    end
  end

  // Enables are masked by reset so an aborted write stops at the current lane.
  assign req_ready = (state_q == IDLE) & ~reset;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign ram_ad    = ad_q;
  assign ram_din   = din_q;
  assign ram_ce    = ce_q & ~reset;
  assign ram_wre   = wre_q & ~reset;
  assign ram_oce   = 1'b1;
  assign ram_reset = reset;

endmodule

// File: tb/tb_bram_word_port.sv
// Randomized self-checking bench for bram_word_port with a byte-array BRAM
// model and an independent word-level reference memory.
module tb_bram_word_port;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wstrb;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic [ADDR_W-1:0] ram_ad;
  logic [7:0]        ram_din;
  logic              ram_ce;
  logic              ram_wre;
  logic              ram_oce;
  logic              ram_reset;
  logic [7:0]        ram_dout;

  logic [7:0]  bram    [DEPTH];
  logic [7:0]  ref_mem [DEPTH];
  bit          mem_init = 1'b0;
  int unsigned pat_seed;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_rdata;

  bram_word_port #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ram_ad    (ram_ad),
    .ram_din   (ram_din),
    .ram_ce    (ram_ce),
    .ram_wre   (ram_wre),
    .ram_oce   (ram_oce),
    .ram_reset (ram_reset),
    .ram_dout  (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 131 + int'(pat_seed)) ^ (i >> 5));
  endfunction

  // 8-bit BRAM in bypass mode: read data appears one clock after issue.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < int'(DEPTH); i++) bram[i] <= init_byte(i);
      mem_init <= 1'b1;
    end else if (ram_ce) begin
      if (ram_wre) bram[ram_ad] <= ram_din;
      else         ram_dout     <= bram[ram_ad];
    end
  end

  function automatic logic [ADDR_W-1:0] lane_addr(input logic [ADDR_W-1:0] a, input int i);
    return ADDR_W'((int'(a) / 4) * 4 + i);
  endfunction

  function automatic logic [31:0] ref_read(input logic [ADDR_W-1:0] a);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = ref_mem[lane_addr(a, i)];
    return r;
  endfunction

  task automatic drive_junk();
    req_we    = 1'($urandom);
    req_addr  = ADDR_W'($urandom);
    req_wdata = $urandom;
    req_wstrb = 4'($urandom);
  endtask

  // One word transaction; optionally scrambles inputs while busy and/or
  // leaves req_valid high so the caller can chain the next request.
  task automatic run_xact(input logic we, input logic [ADDR_W-1:0] a,
                          input logic [31:0] wd, input logic [3:0] ws,
                          input bit junk, input bit chained, input bit keep_valid);
    int lat;
    logic [31:0] exp_rd;
    logic exp_ce, exp_wre;
    logic [ADDR_W-1:0] exp_ad;
    lat    = we ? 5 : 6;
    exp_rd = ref_read(a);
    if (!chained) @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_at_issue addr=%h: got %b expected 1", a, req_ready);
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    req_wstrb = ws;
    @(posedge clk);
    #1;
    if (junk) drive_junk();
    else req_valid = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        exp_ce  = we ? ws[c-1] : 1'b1;
        exp_wre = we ? ws[c-1] : 1'b0;
        exp_ad  = lane_addr(a, c - 1);
        vectors++;
        if ({ram_ce, ram_wre} !== {exp_ce, exp_wre}) begin
          miscompares++;
          $display("FAIL ce_wre C%0d addr=%h we=%b: got %b%b expected %b%b",
                   c, a, we, ram_ce, ram_wre, exp_ce, exp_wre);
        end
        vectors++;
        if (ram_ad !== exp_ad) begin
          miscompares++;
          $display("FAIL ram_ad C%0d: got %h expected %h", c, ram_ad, exp_ad);
        end
        if (we) begin
          vectors++;
          if (ram_din !== wd[8*(c-1) +: 8]) begin
            miscompares++;
            $display("FAIL ram_din C%0d: got %h expected %h", c, ram_din, wd[8*(c-1) +: 8]);
          end
        end
      end else if (!we) begin
        vectors++;
        if (ram_ce !== 1'b0) begin
          miscompares++;
          $display("FAIL ce_tail C%0d: got %b expected 0", c, ram_ce);
        end
      end
      vectors++;
      if (rsp_valid !== (c == lat)) begin
        miscompares++;
        $display("FAIL rsp_valid C%0d we=%b: got %b expected %b", c, we, rsp_valid, (c == lat));
      end
      if (c < lat) begin
        vectors++;
        if (req_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL ready_busy C%0d: got %b expected 0", c, req_ready);
        end
        if (junk) drive_junk();
      end
    end
    if (we) begin
      vectors++;
      if (rsp_rdata !== exp_rdata) begin
        miscompares++;
        $display("FAIL rdata_hold_on_write: got %h expected %h", rsp_rdata, exp_rdata);
      end
      for (int i = 0; i < 4; i++)
        if (ws[i]) ref_mem[lane_addr(a, i)] = wd[8*i +: 8];
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (bram[lane_addr(a, i)] !== ref_mem[lane_addr(a, i)]) begin
          miscompares++;
          $display("FAIL bram_byte %h: got %h expected %h", lane_addr(a, i),
                   bram[lane_addr(a, i)], ref_mem[lane_addr(a, i)]);
        end
      end
    end else begin
      vectors++;
      if (rsp_rdata !== exp_rd) begin
        miscompares++;
        $display("FAIL rsp_rdata addr=%h: got %h expected %h", a, rsp_rdata, exp_rd);
      end
      exp_rdata = exp_rd;
    end
    if (!keep_valid) req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = ADDR_W'(16);
    req_wdata = 32'hFFFF_FFFF;
    req_wstrb = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({req_ready, rsp_valid, ram_ce, ram_wre} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 0000", {req_ready, rsp_valid, ram_ce, ram_wre});
    end
    vectors++;
    if (rsp_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h expected 00000000", rsp_rdata);
    end
    vectors++;
    if ({ram_ad, ram_din} !== '0) begin
      miscompares++;
      $display("FAIL reset_ram_bus: got ad=%h din=%h expected 0", ram_ad, ram_din);
    end
    vectors++;
    if ({ram_oce, ram_reset} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_oce_rst: got %b expected 11", {ram_oce, ram_reset});
    end
    reset     = 1'b0;
    req_valid = 1'b0;
    #1;
    vectors++;
    if ({req_ready, ram_reset} !== 2'b10) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b expected 10", {req_ready, ram_reset});
    end
    exp_rdata = 32'h0;
  endtask

  task automatic test_write_read();
    run_xact(1'b1, ADDR_W'(16), 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({bram[16], bram[17], bram[18], bram[19]} !== 32'hEFBE_ADDE) begin
      miscompares++;
      $display("FAIL wr_bytes: got %h%h%h%h expected EFBEADDE", bram[16], bram[17], bram[18], bram[19]);
    end
    run_xact(1'b0, ADDR_W'(16), 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (rsp_rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL rd_deadbeef: got %h expected DEADBEEF", rsp_rdata);
    end
  endtask

  task automatic test_partial_strobe();
    run_xact(1'b1, ADDR_W'(16), 32'h1122_3344, 4'h5, 1'b0, 1'b0, 1'b0);
    run_xact(1'b0, ADDR_W'(16), 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (rsp_rdata !== 32'hDE22_BE44) begin
      miscompares++;
      $display("FAIL partial_readback: got %h expected DE22BE44", rsp_rdata);
    end
    run_xact(1'b1, ADDR_W'(32), 32'hCAFE_F00D, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_top_addr();
    run_xact(1'b0, ADDR_W'(16'h3FFE), 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    run_xact(1'b1, ADDR_W'(16'h3FFD), $urandom, 4'hF, 1'b0, 1'b0, 1'b0);
    run_xact(1'b0, ADDR_W'(16'h3FFF), 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_xact(1'b0, ADDR_W'(16), 32'h0, 4'h0, 1'b1, 1'b0, 1'b1);
    run_xact(1'b1, ADDR_W'(36), $urandom, 4'($urandom), 1'b1, 1'b1, 1'b1);
    run_xact(1'b0, ADDR_W'(37), 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_write();
    run_xact(1'b1, ADDR_W'(64), 32'h5566_7788, 4'hF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = ADDR_W'(64);
    req_wdata = 32'h0102_0304;
    req_wstrb = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if ({rsp_valid, ram_ce} !== 2'b00) begin
        miscompares++;
        $display("FAIL abort_in_reset: got %b expected 00", {rsp_valid, ram_ce});
      end
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_abort: got %b expected 1", req_ready);
    end
    ref_mem[64] = 8'h04;
    exp_rdata   = 32'h0;
    for (int i = 64; i < 68; i++) begin
      vectors++;
      if (bram[i] !== ref_mem[i]) begin
        miscompares++;
        $display("FAIL abort_byte %0d: got %h expected %h", i, bram[i], ref_mem[i]);
      end
    end
    repeat (6) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_no_rsp: got %b expected 0", rsp_valid);
      end
    end
    run_xact(1'b0, ADDR_W'(66), 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit chain;
    bit keep;
    chain = 1'b0;
    for (int n = 0; n < 60; n++) begin
      keep = (n != 59) && ($urandom_range(0, 1) == 1);
      run_xact(1'($urandom), ADDR_W'(32'h100 + $urandom_range(0, 63)), $urandom,
               4'($urandom), $urandom_range(0, 1) == 1, chain, keep);
      chain = keep;
    end
  endtask

  initial begin
    pat_seed  = $urandom;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_byte(i);
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    exp_rdata = '0;
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_top_addr();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bram_word_port.md
BRAM_WORD_PORT -- requirements
Module: bram_word_port

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, byte-address width of the attached 8-bit dual-port BRAM port (16K x 8).
REQ-002 SHALL have port clk, input, 1: single clock for all logic and for the attached BRAM port.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1: word request present.
REQ-005 SHALL have port req_ready, output, 1: block can accept a request.
REQ-006 SHALL have port req_we, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have port req_addr, input, ADDR_W: byte address; bits [1:0] ignored.
REQ-008 SHALL have port req_wdata, input, 32: write data, little-endian lanes.
REQ-009 SHALL have port req_wstrb, input, 4: per-byte write enables.
REQ-010 SHALL have port rsp_valid, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata, output, 32: read data, valid while rsp_valid=1.
REQ-012 SHALL have port ram_ad, output, ADDR_W: BRAM byte address.
REQ-013 SHALL have port ram_din, output, 8: BRAM write data.
REQ-014 SHALL have port ram_ce, output, 1: BRAM clock enable.
REQ-015 SHALL have port ram_wre, output, 1: BRAM write enable.
REQ-016 SHALL have port ram_oce, output, 1: BRAM output clock enable; constant 1.
REQ-017 SHALL have port ram_reset, output, 1: BRAM reset; equal to reset.
REQ-018 SHALL have port ram_dout, input, 8: BRAM read data, valid one clk after a read is issued (bypass read mode).

Function
REQ-019 SHALL accept a request at a rising edge where req_valid=1 and req_ready=1 (edge T0); it SHALL latch req_we, req_addr, req_wdata and req_wstrb at T0 and ignore later changes.
REQ-020 SHALL drive req_ready=1 only in state IDLE with reset=0.
REQ-021 SHALL implement states IDLE, RD, RD_TAIL and WR, with a 2-bit lane counter.
REQ-022 SHALL set the lane-i BRAM address to {latched_addr[ADDR_W-1:2], i[1:0]}, i = 0..3.
REQ-023 Read: SHALL transition IDLE->RD at T0; in RD cycles C1..C4 it SHALL drive ram_ce=1, ram_wre=0 and ram_ad = lane 0..3.
REQ-024 Read capture: SHALL capture ram_dout at the end of cycles C2..C5 into rsp_rdata[8i+7:8i] for lanes 0..3.
REQ-025 Read timing: after C4, SHALL enter RD_TAIL (C5) with ram_ce=0, then return to IDLE; rsp_valid SHALL be 1 in C6 only.
REQ-026 Write: SHALL transition IDLE->WR at T0; in WR cycles C1..C4 it SHALL drive ram_ad = lane i, ram_din = wdata[8i+7:8i], and ram_ce = ram_wre = wstrb[i].
REQ-027 Write timing: SHALL return to IDLE after C4 and pulse rsp_valid in C5; rsp_rdata SHALL hold its previous value on write completion.
REQ-028 Write latency SHALL be fixed at 4 cycles regardless of wstrb; wstrb=0 SHALL produce no BRAM write.
REQ-029 IDLE outputs: ram_ce=0, ram_wre=0, ram_ad=0, ram_din=0.
REQ-030 Back-to-back: SHALL accept a new request in the same cycle rsp_valid=1 (state is IDLE); zero bubble beyond the fixed latency.
REQ-031 req_valid asserted while busy SHALL be ignored until req_ready=1; no request is queued.
REQ-032 Address arithmetic SHALL not carry: lanes never cross a word boundary.

Reset
REQ-033 While reset=1, at every clk edge the block SHALL force state=IDLE, lane=0, rsp_valid=0, rsp_rdata=0, ram_ce=0, ram_wre=0, ram_ad=0 and ram_din=0, and hold req_ready=0.
REQ-034 Reset asserted mid-operation SHALL abort the transfer with no rsp_valid; lanes already written remain written; req_ready=1 in the first cycle after reset deasserts.

Verification
REQ-035 Write then read: write addr 0x0010, wdata 0xDEADBEEF, wstrb 0xF -> BRAM bytes 0x10..0x13 = EF,BE,AD,DE; rsp_valid in C5; a following read of 0x0010 -> rsp_rdata=0xDEADBEEF with rsp_valid in C6.
REQ-036 Partial strobe: with the word preset to 0xDEADBEEF, write wdata 0x11223344, wstrb 0x5 -> readback 0xDE22BE44; ram_wre=0 in C2 and C4.
REQ-037 Misaligned/top address: read req_addr 0x3FFE -> ram_ad sequence 0x3FFC, 0x3FFD, 0x3FFE, 0x3FFF with no wrap to 0x0000.
REQ-038 Busy/back-to-back: hold req_valid=1 with changing fields during a read -> only the T0 values are used; a second request is accepted in the C6 cycle, and its C1 immediately follows.
REQ-039 Reset mid-write: assert reset in C2 of a wstrb=0xF write -> no rsp_valid; only byte lane 0 is modified; req_ready=1 in the first cycle after release.
